pipe_hazard_ctrl: RTL and testbench

- Sequencing controller for the 5-stage MIPS pipeline.
- Drives the enable/flush pins of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB register banks, which are built from the enable+synchronous-reset flip-flops.
- Resolves load-use stalls, taken-branch squashes, multi-cycle MDU (mul/div) occupancy and data-memory wait states.
- Keeps a saturating stall-cycle counter.

---
 rtl/pipe_pkg.sv | 10 +
 rtl/sat_counter.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_pkg;
    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         MDU_LAT_DEF = 4;
endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - enable/flush sequencing for the 5-stage pipeline
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEF,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             r_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_br_taken,
    input  logic             ex_mdu_start,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             mdu_busy,
    input  logic             stall_cnt_clr,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam logic [3:0] MDU_RELOAD = 4'(MDU_LAT - 1);

    state_e     state_q;
    state_e     state_d;
    logic [3:0] mdu_cnt_q;
    logic [3:0] mdu_cnt_d;
    logic       mem_wait;
    logic       load_use;

    assign mem_wait = mem_req && !mem_ready;
    assign load_use = ex_memread && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        state_d     = state_q;
        mdu_cnt_d   = mdu_cnt_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (!r_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (mem_wait) begin
            // Whole pipe frozen; only WB drains with a bubble.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (state_q == MDU_BUSY) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = (mdu_cnt_q != 4'd1);
            mdu_cnt_d   = mdu_cnt_q - 4'd1;
            if (mdu_cnt_q == 4'd1) begin
                state_d = RUN;
            end
        end else if (ex_mdu_start && (MDU_LAT > 1)) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            state_d     = MDU_BUSY;
            mdu_cnt_d   = MDU_RELOAD;
        end else if (ex_br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            state_q   <= RUN;
            mdu_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

    assign mdu_busy = (state_q == MDU_BUSY);

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(r_n),
        .clr  (stall_cnt_clr),
        .inc  (!pc_en && r_n),
        .cnt  (stall_cnt)
    );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             r_n;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_memread, ex_br_taken, ex_mdu_start;
    logic             mem_req, mem_ready, stall_cnt_clr;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, exmem_flush, memwb_flush, mdu_busy;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int m_left   = 0;
    int m_cnt    = 0;
    int zeros;
    logic obs_pc_en;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .r_n(r_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken),
        .ex_mdu_start(ex_mdu_start), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .mdu_busy(mdu_busy),
        .stall_cnt_clr(stall_cnt_clr), .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic idle();
        r_n = 1'b1; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_memread = 1'b0; ex_rt = 5'd0; ex_br_taken = 1'b0; ex_mdu_start = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b1; stall_cnt_clr = 1'b0;
    endtask

    // One clock: compare against the model mid-cycle, then advance the model.
    task automatic cycle();
        logic [9:0] e;
        logic       mw, lu;
        @(negedge clk);
        if (!r_n) begin
            m_left = 0;
            m_cnt  = 0;
        end
        mw = mem_req && !mem_ready;
        lu = ex_memread && ex_rt != 0 &&
             (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        // order: pc ifid idex exmem memwb | f_ifid f_idex f_exmem f_memwb | busy
        e = 10'b11111_0000_0;
        if (!r_n)                                   e = 10'b00000_1111_0;
        else if (mw)                                e = {5'b00001, 4'b0001, m_left > 0};
        else if (m_left > 0)                        e = {5'b00011, 2'b00, m_left != 1, 1'b0, 1'b1};
        else if (ex_mdu_start && MDU_LAT > 1)       e = 10'b00011_0010_0;
        else if (ex_br_taken)                       e = 10'b11111_1100_0;
        else if (lu)                                e = 10'b00111_0100_0;
        obs_pc_en = pc_en;
        check("ctrl", {22'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                       ifid_flush, idex_flush, exmem_flush, memwb_flush, mdu_busy},
              {22'd0, e});
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        if (r_n) begin
            if (stall_cnt_clr) m_cnt = 0;
            else if (!e[9] && m_cnt < CNT_MAX) m_cnt++;
            if (!mw) begin
                if (m_left > 0) m_left--;
                else if (ex_mdu_start && MDU_LAT > 1) m_left = MDU_LAT - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cnt();
        idle();
        stall_cnt_clr = 1'b1;
        cycle();
        idle();
    endtask

    initial begin
        idle();
        r_n = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        idle();
        cycle();

        // load-use on rs, then the same with $0
        clear_cnt();
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        cycle();
        idle();
        cycle();
        check("lu_cnt", 32'(stall_cnt), 32'd1);
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        cycle();
        idle();
        cycle();
        check("lu_zero_cnt", 32'(stall_cnt), 32'd1);

        // taken branch beats load-use on rt
        ex_memread = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1; ex_br_taken = 1'b1;
        cycle();
        idle();
        cycle();
        check("br_cnt", 32'(stall_cnt), 32'd1);

        // plain MDU op
        clear_cnt();
        zeros = 0;
        ex_mdu_start = 1'b1;
        cycle();
        if (!obs_pc_en) zeros++;
        idle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (!obs_pc_en) zeros++;
        end
        check("mdu_span", 32'(zeros), 32'(MDU_LAT));
        check("mdu_cnt", 32'(stall_cnt), 32'(MDU_LAT));

        // MEM wait landing in the second MDU cycle
        clear_cnt();
        zeros = 0;
        ex_mdu_start = 1'b1;
        cycle();
        if (!obs_pc_en) zeros++;
        idle();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            if (!obs_pc_en) zeros++;
        end
        idle();
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (!obs_pc_en) zeros++;
        end
        check("memwait_span", 32'(zeros), 32'd6);

        // saturation then clear-beats-increment
        clear_cnt();
        ex_memread = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
        for (int i = 0; i < 20; i++) cycle();
        check("sat_cnt", 32'(stall_cnt), 32'(CNT_MAX));
        stall_cnt_clr = 1'b1;
        cycle();
        check("clr_cnt", 32'(stall_cnt), 32'd0);

        // reset in the middle of an MDU op leaves no residue
        idle();
        ex_mdu_start = 1'b1;
        cycle();
        idle();
        cycle();
        r_n = 1'b0;
        cycle();
        idle();
        for (int i = 0; i < 3; i++) cycle();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            r_n           = ($urandom_range(0, 199) != 0);
            id_rs         = 5'($urandom_range(0, 3));
            id_rt         = 5'($urandom_range(0, 3));
            id_uses_rt    = 1'($urandom_range(0, 1));
            ex_memread    = ($urandom_range(0, 9) < 4);
            ex_rt         = 5'($urandom_range(0, 3));
            ex_br_taken   = ($urandom_range(0, 9) < 2);
            ex_mdu_start  = ($urandom_range(0, 9) == 0);
            mem_req       = ($urandom_range(0, 9) < 3);
            mem_ready     = ($urandom_range(0, 9) < 5);
            stall_cnt_clr = ($urandom_range(0, 29) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
